// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory port between the instruction-fetch (IF) and load/store (LS)
// requesters. One transaction is outstanding at a time. LS has fixed priority,
// but after STARVE_MAX consecutive LS grants with IF waiting, IF wins once.
// Responses are routed back to the requester that owns the transaction.
//
// Ports:
//   sys_clk, sys_rst                 clock, asynchronous active-low reset
//   if_req_valid/ready, if_addr      fetch request handshake and address
//   if_rsp_valid/data                fetch response
//   ls_req_valid/ready, ls_addr,
//   ls_wen, ls_wdata, ls_wmask       load/store request
//   ls_rsp_valid/data                load data or store acknowledge
//   mem_req_valid/ready, mem_addr,
//   mem_wen, mem_wdata, mem_wmask    request to the unified memory interface
//   mem_rsp_valid/data               memory response
//   busy                             a transaction is in flight
//   err_spurious                     sticky: memory responded with nothing pending
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst,

    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_data,

    input  logic              ls_req_valid,
    output logic              ls_req_ready,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic              ls_wen,
    input  logic [DATA_W-1:0] ls_wdata,
    input  logic [7:0]        ls_wmask,
    output logic              ls_rsp_valid,
    output logic [DATA_W-1:0] ls_rsp_data,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [7:0]        mem_wmask,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,

    output logic              busy,
    output logic              err_spurious
);

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWaitRsp
    } state_e;

    state_e              state_q;
    logic                owner_q;      // 0 = IF, 1 = LS
    logic [ADDR_W-1:0]   addr_q;
    logic                wen_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [7:0]          wmask_q;
    logic [3:0]          starve_cnt_q;
    logic                err_q;

    logic idle;
    logic if_starving;
    logic grant_ls;
    logic grant_if;
    logic rsp_hit;

    // Grant decision. Gated by reset so both readies read 0 while reset is held,
    // even though requesters may already be presenting valid.
    always_comb begin
        idle        = (state_q == StIdle) && sys_rst;
        if_starving = if_req_valid && (starve_cnt_q == StarveMax);
        grant_ls    = idle && ls_req_valid && !if_starving;
        grant_if    = idle && if_req_valid && !grant_ls;
        rsp_hit     = (state_q == StWaitRsp) && mem_rsp_valid;
    end

    always_comb begin
        if_req_ready  = grant_if;
        ls_req_ready  = grant_ls;

        if_rsp_valid  = rsp_hit && !owner_q;
        ls_rsp_valid  = rsp_hit && owner_q;
        if_rsp_data   = if_rsp_valid ? mem_rsp_data : '0;
        ls_rsp_data   = ls_rsp_valid ? mem_rsp_data : '0;

        mem_req_valid = (state_q == StReq);
        mem_addr      = addr_q;
        mem_wen       = wen_q;
        mem_wdata     = wdata_q;
        mem_wmask     = wmask_q;

        busy          = (state_q != StIdle);
        err_spurious  = err_q;
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            starve_cnt_q <= '0;
            err_q        <= 1'b0;
        end else begin
            // A response with no transaction waiting for it is dropped but remembered.
            if (mem_rsp_valid && (state_q != StWaitRsp)) begin
                err_q <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (grant_ls) begin
                        owner_q <= 1'b1;
                        addr_q  <= ls_addr;
                        wen_q   <= ls_wen;
                        wdata_q <= ls_wdata;
                        wmask_q <= ls_wmask;
                        state_q <= StReq;
                        // Only count LS wins that actually kept IF waiting.
                        if (if_req_valid) begin
                            if (starve_cnt_q != StarveMax) begin
                                starve_cnt_q <= starve_cnt_q + 4'd1;
                            end
                        end else begin
                            starve_cnt_q <= '0;
                        end
                    end else if (grant_if) begin
                        owner_q      <= 1'b0;
                        addr_q       <= if_addr;
                        wen_q        <= 1'b0;
                        wdata_q      <= '0;
                        wmask_q      <= '0;
                        starve_cnt_q <= '0;
                        state_q      <= StReq;
                    end
                end
                StReq: begin
                    if (mem_req_ready) begin
                        state_q <= StWaitRsp;
                    end
                end
                StWaitRsp: begin
                    if (mem_rsp_valid) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
